// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response and decode handshake.
// master = fetch unit, slave = memory/decode side.
interface instr_fetch_unit_if #(
    parameter int unsigned INSTR_ADDR_WIDTH = 32,
    parameter int unsigned INSTR_WIDTH      = 32
);
    logic                        imem_req_valid;
    logic                        imem_req_ready;
    logic [INSTR_ADDR_WIDTH-1:0] imem_req_addr;
    logic                        imem_rsp_valid;
    logic [INSTR_WIDTH-1:0]      imem_rsp_data;

    logic                        instr_valid;
    logic                        instr_ready;
    logic [INSTR_WIDTH-1:0]      instr_data;
    logic [INSTR_ADDR_WIDTH-1:0] instr_addr;
    logic                        instr_len;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output instr_valid, instr_data, instr_addr, instr_len,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instr_data, instr_addr, instr_len,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: credit-limited in-order memory requests, tagged instruction
// buffer toward decode, and flush handling that discards stale in-flight responses.
module instr_fetch_unit #(
    parameter int unsigned INSTR_ADDR_WIDTH = 32,
    parameter int unsigned INSTR_WIDTH      = 32,
    parameter int unsigned FIFO_DEPTH       = 4,
    parameter int unsigned MAX_OUTSTANDING  = 2
) (
    input  logic                            clk,
    input  logic                            async_rst_n,
    input  logic                            clk_en,
    input  logic [INSTR_ADDR_WIDTH-1:0]     fetch_addr,
    input  logic                            flush,
    output logic                            pc_stall,
    instr_fetch_unit_if.master              bus,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            rsp_err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned AQ_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0]      data;
        logic [INSTR_ADDR_WIDTH-1:0] addr;
        logic                        len;
    } fifo_entry_t;

    fifo_entry_t                 fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic [CNT_W-1:0]            count;

    logic [INSTR_ADDR_WIDTH-1:0] aq_mem [MAX_OUTSTANDING];
    logic [AQ_W-1:0]             aq_wr;
    logic [AQ_W-1:0]             aq_rd;
    logic [OUT_W-1:0]            outstanding;
    logic [OUT_W-1:0]            discard;

    logic        credit_ok_c;
    logic        req_valid_c;
    logic        accept_c;
    logic        rsp_c;
    logic        spurious_c;
    logic        rsp_pop_c;
    logic        rsp_drop_c;
    logic        fifo_wr_c;
    logic        fifo_rd_c;
    fifo_entry_t head_c;
    fifo_entry_t wr_entry_c;

    function automatic logic [AQ_W-1:0] aq_inc(input logic [AQ_W-1:0] p);
        return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + AQ_W'(1);
    endfunction

    // Credits come from registered counts only, so a same-cycle pop never over-issues.
    always_comb begin
        credit_ok_c = (32'(outstanding) < MAX_OUTSTANDING) &&
                      ((32'(count) + 32'(outstanding)) < FIFO_DEPTH);
        req_valid_c = async_rst_n & clk_en & ~flush & credit_ok_c;
        accept_c    = req_valid_c & bus.imem_req_ready;
        rsp_c       = clk_en & bus.imem_rsp_valid;
        spurious_c  = rsp_c & (outstanding == '0);
        rsp_pop_c   = rsp_c & (outstanding != '0);
        rsp_drop_c  = rsp_pop_c & (flush | (discard != '0));
        fifo_wr_c   = rsp_pop_c & ~rsp_drop_c;
        fifo_rd_c   = clk_en & ~flush & (count != '0) & bus.instr_ready;
    end

    always_comb begin
        wr_entry_c      = '0;
        wr_entry_c.data = bus.imem_rsp_data;
        wr_entry_c.addr = aq_mem[aq_rd];
        wr_entry_c.len  = (bus.imem_rsp_data[1:0] == 2'b11);
        head_c          = fifo_mem[rd_ptr];
    end

    // Control state: pointers, occupancy, in-flight and discard counters, sticky error.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            aq_wr       <= '0;
            aq_rd       <= '0;
            outstanding <= '0;
            discard     <= '0;
            rsp_err     <= 1'b0;
        end else if (clk_en) begin
            if (accept_c)  aq_wr <= aq_inc(aq_wr);
            if (rsp_pop_c) aq_rd <= aq_inc(aq_rd);
            outstanding <= outstanding + OUT_W'(accept_c) - OUT_W'(rsp_pop_c);

            // On flush every remaining in-flight response is stale.
            if (flush)
                discard <= outstanding - OUT_W'(rsp_pop_c);
            else if (rsp_drop_c)
                discard <= discard - OUT_W'(1);

            if (spurious_c) rsp_err <= 1'b1;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (fifo_wr_c) wr_ptr <= wr_ptr + PTR_W'(1);
                if (fifo_rd_c) rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(fifo_wr_c) - CNT_W'(fifo_rd_c);
            end
        end
    end

    // Storage arrays carry no reset; validity is tracked by the control state above.
    always_ff @(posedge clk) begin
        if (accept_c)  aq_mem[aq_wr]    <= fetch_addr;
        if (fifo_wr_c) fifo_mem[wr_ptr] <= wr_entry_c;
    end

    assign pc_stall           = ~accept_c;
    assign bus.imem_req_valid = req_valid_c;
    assign bus.imem_req_addr  = fetch_addr;
    assign bus.instr_valid    = clk_en & (count != '0);
    assign bus.instr_data     = head_c.data;
    assign bus.instr_addr     = head_c.addr;
    assign bus.instr_len      = head_c.len;
    assign fifo_count         = count;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (async_rst_n && clk_en) begin
            assert (!(fifo_wr_c && !fifo_rd_c && !flush && (32'(count) == FIFO_DEPTH)))
                else $error("instruction buffer written while full");
            assert (32'(discard) <= 32'(outstanding))
                else $error("discard count exceeds in-flight requests");
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, back-pressure, flush, length decode,
// clock enable, spurious response and asynchronous reset.
module tb_instr_fetch_unit;

    logic        clk;
    logic        async_rst_n;
    logic        clk_en;
    logic [31:0] fetch_addr;
    logic        flush;
    logic        pc_stall;
    logic [2:0]  fifo_count;
    logic        rsp_err;

    instr_fetch_unit_if #(.INSTR_ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    instr_fetch_unit #(
        .INSTR_ADDR_WIDTH(32),
        .INSTR_WIDTH     (32),
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk        (clk),
        .async_rst_n(async_rst_n),
        .clk_en     (clk_en),
        .fetch_addr (fetch_addr),
        .flush      (flush),
        .pc_stall   (pc_stall),
        .bus        (bus),
        .fifo_count (fifo_count),
        .rsp_err    (rsp_err)
    );

    int errors = 0;
    int checks = 0;
    bit mem_auto = 0;
    bit auto_pc  = 0;
    logic [31:0] pend[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a << 4) | 32'h3;
    endfunction

    // One clock: bench-side memory (1-cycle latency) and PC model advance here.
    task automatic cycle();
        logic acc;
        logic [31:0] a;
        acc = bus.imem_req_valid & bus.imem_req_ready;
        if (mem_auto && acc) pend.push_back(fetch_addr);
        @(posedge clk);
        #1;
        if (auto_pc && acc) fetch_addr = fetch_addr + 32'd2;
        if (mem_auto) begin
            if (pend.size() > 0) begin
                a = pend.pop_front();
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(a);
            end else begin
                bus.imem_rsp_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        async_rst_n        = 1'b0;
        clk_en             = 1'b1;
        flush              = 1'b0;
        fetch_addr         = 32'h0;
        mem_auto           = 0;
        auto_pc            = 0;
        pend.delete();
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.instr_ready    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        async_rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        async_rst_n        = 1'b0;
        clk_en             = 1'b1;
        flush              = 1'b0;
        fetch_addr         = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.instr_ready    = 1'b1;
        @(posedge clk);
        #2;
        checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL reset_pc_stall: got %b expected 1", pc_stall); end
        checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", bus.instr_valid); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    endtask

    task automatic test_streaming();
        logic [31:0] exp;
        do_reset();
        mem_auto = 1; auto_pc = 1;
        bus.instr_ready = 1'b1;
        exp = 32'h0;
        for (int i = 0; i < 12; i++) begin
            checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL stream_pc_stall[%0d]: got %b expected 0", i, pc_stall); end
            if (i >= 2) begin
                checks++;
                if (bus.instr_valid !== 1'b1 || bus.instr_addr !== exp) begin
                    errors++; $display("FAIL stream_addr[%0d]: got valid=%b addr=%h expected valid=1 addr=%h", i, bus.instr_valid, bus.instr_addr, exp);
                end
                checks++;
                if (bus.instr_data !== mem_word(exp)) begin
                    errors++; $display("FAIL stream_data[%0d]: got %h expected %h", i, bus.instr_data, mem_word(exp));
                end
                exp = exp + 32'd2;
            end
            cycle();
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] exp;
        int got;
        do_reset();
        mem_auto = 1; auto_pc = 1;
        fetch_addr = 32'h100;
        bus.instr_ready = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) cycle();
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_fifo_count: got %0d expected 4", fifo_count); end
        checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b expected 0", bus.imem_req_valid); end
        checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL bp_pc_stall: got %b expected 1", pc_stall); end
        checks++; if (bus.instr_addr !== 32'h100 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL bp_head_stable: got valid=%b addr=%h expected valid=1 addr=00000100", bus.instr_valid, bus.instr_addr); end
        cycle();
        cycle();
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_fifo_hold: got %0d expected 4", fifo_count); end
        auto_pc = 0;
        bus.instr_ready = 1'b1;
        #1;
        exp = 32'h100;
        got = 0;
        for (int i = 0; i < 20 && got < 4; i++) begin
            if (bus.instr_valid === 1'b1) begin
                checks++;
                if (bus.instr_addr !== exp) begin errors++; $display("FAIL bp_drain[%0d]: got %h expected %h", got, bus.instr_addr, exp); end
                exp = exp + 32'd2;
                got++;
            end
            cycle();
        end
        checks++; if (got != 4) begin errors++; $display("FAIL bp_drain_count: got %0d expected 4", got); end
    endtask

    task automatic test_flush();
        do_reset();
        fetch_addr = 32'h200;
        #1;
        cycle();
        fetch_addr = 32'h204;
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h1111_0003;
        cycle();
        fetch_addr = 32'h208;
        bus.imem_rsp_valid = 1'b0;
        cycle();
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL flush_pre_count: got %0d expected 1", fifo_count); end
        flush = 1'b1;
        fetch_addr = 32'h300;
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h2222_0003;
        bus.instr_ready = 1'b1;
        #1;
        checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL flush_req_valid: got %b expected 0", bus.imem_req_valid); end
        checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL flush_pc_stall: got %b expected 1", pc_stall); end
        cycle();
        flush = 1'b0;
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h3333_0003;
        #1;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL flush_instr_valid: got %b expected 0", bus.instr_valid); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", fifo_count); end
        checks++; if (pc_stall !== 1'b0 || bus.imem_req_addr !== 32'h300) begin errors++; $display("FAIL flush_reissue: got stall=%b addr=%h expected stall=0 addr=00000300", pc_stall, bus.imem_req_addr); end
        cycle();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0013;
        #1;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL flush_second_drop: got %0d expected 0", fifo_count); end
        cycle();
        bus.imem_rsp_valid = 1'b0;
        #1;
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_addr !== 32'h300 || bus.instr_data !== 32'h13) begin
            errors++; $display("FAIL flush_target: got valid=%b addr=%h data=%h expected valid=1 addr=00000300 data=00000013", bus.instr_valid, bus.instr_addr, bus.instr_data);
        end
    endtask

    task automatic test_length();
        do_reset();
        fetch_addr = 32'h500;
        #1;
        cycle();
        fetch_addr = 32'h502;
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0013;
        cycle();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_data = 32'h0000_4501;
        cycle();
        bus.imem_rsp_valid = 1'b0;
        bus.instr_ready = 1'b1;
        #1;
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL len_count: got %0d expected 2", fifo_count); end
        checks++; if (bus.instr_addr !== 32'h500 || bus.instr_len !== 1'b1) begin errors++; $display("FAIL len_32bit: got addr=%h len=%b expected addr=00000500 len=1", bus.instr_addr, bus.instr_len); end
        cycle();
        checks++; if (bus.instr_addr !== 32'h502 || bus.instr_len !== 1'b0 || bus.instr_data !== 32'h4501) begin errors++; $display("FAIL len_16bit: got addr=%h len=%b data=%h expected addr=00000502 len=0 data=00004501", bus.instr_addr, bus.instr_len, bus.instr_data); end
    endtask

    task automatic test_clk_en();
        do_reset();
        fetch_addr = 32'h400;
        #1;
        cycle();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0013;
        cycle();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready = 1'b1;
        clk_en = 1'b0;
        #1;
        checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req_valid !== 1'b0 || pc_stall !== 1'b1) begin errors++; $display("FAIL clken_outputs: got ivalid=%b rvalid=%b stall=%b expected 0 0 1", bus.instr_valid, bus.imem_req_valid, pc_stall); end
        for (int i = 0; i < 3; i++) cycle();
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL clken_frozen: got %0d expected 1", fifo_count); end
        bus.imem_req_ready = 1'b0;
        clk_en = 1'b1;
        #1;
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_addr !== 32'h400) begin errors++; $display("FAIL clken_resume: got valid=%b addr=%h expected valid=1 addr=00000400", bus.instr_valid, bus.instr_addr); end
    endtask

    task automatic test_spurious_and_reset();
        do_reset();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0013;
        #1;
        cycle();
        bus.imem_rsp_valid = 1'b0;
        #1;
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL spur_err_set: got %b expected 1", rsp_err); end
        checks++; if (fifo_count !== 3'd0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL spur_fifo: got count=%0d valid=%b expected 0 0", fifo_count, bus.instr_valid); end
        for (int i = 0; i < 3; i++) cycle();
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL spur_err_sticky: got %b expected 1", rsp_err); end
        mem_auto = 1; auto_pc = 1;
        fetch_addr = 32'h600;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) cycle();
        checks++; if (fifo_count === 3'd0) begin errors++; $display("FAIL midrst_prefill: got count=%0d expected nonzero", fifo_count); end
        #2;
        async_rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_err !== 1'b0 || fifo_count !== 3'd0 || bus.instr_valid !== 1'b0 ||
            bus.imem_req_valid !== 1'b0 || pc_stall !== 1'b1) begin
            errors++; $display("FAIL midrst_clear: got err=%b count=%0d ivalid=%b rvalid=%b stall=%b expected 0 0 0 0 1",
                               rsp_err, fifo_count, bus.instr_valid, bus.imem_req_valid, pc_stall);
        end
        mem_auto = 0;
        pend.delete();
        @(posedge clk);
        #1;
        async_rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_length();
        test_clk_en();
        test_spurious_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
